// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, status bit positions
// and the bit-period computation.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned DAVAIL = 8;
    localparam int unsigned ERR    = 9;

    // Rounded clock cycles per bit.
    function automatic logic [15:0] calc_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned q;
        q = (clk_hz + baud / 2) / baud;
        return q[15:0];
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer; DEPTH of 1 degenerates to a single holding register.
// A push into a full buffer is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a bus-readable status/data word.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 20000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       valid,
    input  logic       wr,
    output logic [9:0] dout
);

`ifdef UART_RX_FIFO_EN
    localparam int unsigned DEPTH = FIFO_DEPTH;
`else
    localparam int unsigned DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif

    localparam logic [15:0] DIV  = calc_div(CLK_HZ, BAUD);
    localparam logic [15:0] HALF = DIV >> 1;

    logic       rxd_meta, rxd_sync;
    logic [1:0] sync_ok_q;
    logic       armed_q, armed_d;
    rx_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       push, frame_err;

    logic       valid_q, wr_q, err_q;
    logic       rd_fall, wr_fall, pop, overrun;
    logic [7:0] head;
    logic       empty, full;
    logic [9:0] dout_q, dout_next;

    // Synchronizer reset values are not a real line observation, so arming waits
    // until sync_ok shows both flops hold sampled data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            sync_ok_q <= 2'b00;
        end else begin
            rxd_meta  <= rxd;
            rxd_sync  <= rxd_meta;
            sync_ok_q <= {sync_ok_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (sync_ok_q[1] && rxd_sync) begin
                    armed_d = 1'b1;
                end else if (armed_q && !rxd_sync) begin
                    state_d = StStart;
                    armed_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == HALF - 16'd1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_sync ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == DIV - 16'd1) begin
                    cnt_d   = '0;
                    shreg_d = {rxd_sync, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == DIV - 16'd1) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    push      = rxd_sync;
                    frame_err = !rxd_sync;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shreg_q),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    // Bus side acts on the falling edge of valid so each transaction counts once.
    assign rd_fall = valid_q && !valid && !wr_q;
    assign wr_fall = valid_q && !valid && wr_q;
    assign pop     = rd_fall && !empty;
    assign overrun = push && full && !pop;

    always_comb begin
        dout_next         = '0;
        dout_next[7:0]    = empty ? 8'h00 : head;
        dout_next[DAVAIL] = !empty;
        dout_next[ERR]    = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= valid;
            if (valid) begin
                wr_q <= wr;
            end
            if (frame_err || overrun) begin
                err_q <= 1'b1;
            end else if (wr_fall) begin
                err_q <= 1'b0;
            end
            if (!valid) begin
                dout_q <= dout_next;
            end
        end
    end

    assign dout = dout_q;

endmodule
